id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: instruction decode stage and ID/EX pipeline register for a
// five-stage MIPS-style pipeline.
//
// Decodes the IF/ID instruction, reads register operands (with writeback
// bypass), detects load-use hazards against the instruction currently in EX,
// and registers the decoded fields into the ID/EX boundary. A bubble is loaded
// on stall, on EX flush, or when IF/ID is empty. A saturating counter tracks
// the number of stall cycles.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_instr, i_pc_plus4, i_valid   IF/ID contents
//   o_rs_addr, o_rt_addr           register-file read addresses (combinational)
//   i_data_rs, i_data_rt           register-file read data
//   i_wb_we, i_wb_addr, i_wb_data  writeback port, bypassed into operand reads
//   i_ex_flush                     taken branch in EX; kill the ID instruction
//   o_stall                        load-use stall (combinational)
//   o_valid ... o_branch           registered ID/EX fields
//   o_stall_cnt                    saturating stall-cycle count
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      i_instr,
    input  logic [31:0]      i_pc_plus4,
    input  logic             i_valid,
    output logic [4:0]       o_rs_addr,
    output logic [4:0]       o_rt_addr,
    input  logic [31:0]      i_data_rs,
    input  logic [31:0]      i_data_rt,
    input  logic             i_wb_we,
    input  logic [4:0]       i_wb_addr,
    input  logic [31:0]      i_wb_data,
    input  logic             i_ex_flush,
    output logic             o_stall,
    output logic             o_valid,
    output logic [31:0]      o_rs_data,
    output logic [31:0]      o_rt_data,
    output logic [31:0]      o_imm,
    output logic [4:0]       o_rs,
    output logic [4:0]       o_rt,
    output logic [4:0]       o_dst,
    output logic [31:0]      o_pc_plus4,
    output logic [5:0]       o_opcode,
    output logic [5:0]       o_funct,
    output logic             o_reg_write,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_mem_to_reg,
    output logic             o_alu_src,
    output logic             o_branch,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  rs_f, rt_f, rd_f;
    logic [15:0] imm16;

    assign opcode = i_instr[31:26];
    assign rs_f   = i_instr[25:21];
    assign rt_f   = i_instr[20:16];
    assign rd_f   = i_instr[15:11];
    assign imm16  = i_instr[15:0];

    assign o_rs_addr = rs_f;
    assign o_rt_addr = rt_f;

    // Decoded (pre-register) controls
    logic [4:0]  dec_dst;
    logic        dec_reg_write, dec_mem_read, dec_mem_write;
    logic        dec_mem_to_reg, dec_alu_src, dec_branch;
    logic        dec_uses_rt;
    logic [31:0] dec_imm;

    always_comb begin
        dec_dst        = 5'd0;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_alu_src    = 1'b0;
        dec_branch     = 1'b0;
        dec_uses_rt    = 1'b0;
        dec_imm        = 32'd0;
        unique case (opcode)
            OP_RTYPE: begin
                dec_dst       = rd_f;
                dec_reg_write = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            OP_ADDI: begin
                dec_dst       = rt_f;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = {{16{imm16[15]}}, imm16};
            end
            OP_ANDI, OP_ORI: begin
                dec_dst       = rt_f;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = {16'h0, imm16};
            end
            OP_LUI: begin
                dec_dst       = rt_f;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = {imm16, 16'h0};
            end
            OP_LW: begin
                dec_dst        = rt_f;
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_alu_src    = 1'b1;
                dec_imm        = {{16{imm16[15]}}, imm16};
            end
            OP_SW: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_uses_rt   = 1'b1;
                dec_imm       = {{16{imm16[15]}}, imm16};
            end
            OP_BEQ: begin
                dec_branch  = 1'b1;
                dec_uses_rt = 1'b1;
                dec_imm     = {{16{imm16[15]}}, imm16};
            end
            default: ;
        endcase
        // Writes to $0 are architecturally dropped; clear the enable so EX/WB
        // never see a live write to the zero register.
        if (dec_dst == 5'd0)
            dec_reg_write = 1'b0;
    end

    // Registered state
    logic             valid_q, valid_d;
    logic [31:0]      rs_data_q, rs_data_d;
    logic [31:0]      rt_data_q, rt_data_d;
    logic [31:0]      imm_q, imm_d;
    logic [4:0]       rs_q, rs_d;
    logic [4:0]       rt_q, rt_d;
    logic [4:0]       dst_q, dst_d;
    logic [31:0]      pc_plus4_q, pc_plus4_d;
    logic [5:0]       opcode_q, opcode_d;
    logic [5:0]       funct_q, funct_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             mem_to_reg_q, mem_to_reg_d;
    logic             alu_src_q, alu_src_d;
    logic             branch_q, branch_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic stall;
    logic bubble;

    // Load-use hazard: the load in EX produces its data too late for this
    // instruction. rt only counts as a source for R-type, SW and BEQ.
    always_comb begin
        stall = i_valid && valid_q && mem_read_q && (dst_q != 5'd0)
                && ((dst_q == rs_f) || (dec_uses_rt && (dst_q == rt_f)))
                && !i_ex_flush;
    end

    assign bubble  = stall || i_ex_flush || !i_valid;
    assign o_stall = stall;

    always_comb begin
        // Writeback bypass covers the same-cycle register-file write.
        rs_data_d = (i_wb_we && (i_wb_addr != 5'd0) && (i_wb_addr == rs_f))
                    ? i_wb_data : i_data_rs;
        rt_data_d = (i_wb_we && (i_wb_addr != 5'd0) && (i_wb_addr == rt_f))
                    ? i_wb_data : i_data_rt;
        imm_d        = dec_imm;
        rs_d         = rs_f;
        rt_d         = rt_f;
        pc_plus4_d   = i_pc_plus4;
        opcode_d     = opcode;
        funct_d      = i_instr[5:0];
        valid_d      = !bubble;
        dst_d        = bubble ? 5'd0 : dec_dst;
        reg_write_d  = !bubble && dec_reg_write;
        mem_read_d   = !bubble && dec_mem_read;
        mem_write_d  = !bubble && dec_mem_write;
        mem_to_reg_d = !bubble && dec_mem_to_reg;
        alu_src_d    = !bubble && dec_alu_src;
        branch_d     = !bubble && dec_branch;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            rs_data_q    <= 32'd0;
            rt_data_q    <= 32'd0;
            imm_q        <= 32'd0;
            rs_q         <= 5'd0;
            rt_q         <= 5'd0;
            dst_q        <= 5'd0;
            pc_plus4_q   <= 32'd0;
            opcode_q     <= 6'd0;
            funct_q      <= 6'd0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_q    <= 1'b0;
            branch_q     <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            dst_q        <= dst_d;
            pc_plus4_q   <= pc_plus4_d;
            opcode_q     <= opcode_d;
            funct_q      <= funct_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_src_q    <= alu_src_d;
            branch_q     <= branch_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_rs_data    = rs_data_q;
    assign o_rt_data    = rt_data_q;
    assign o_imm        = imm_q;
    assign o_rs         = rs_q;
    assign o_rt         = rt_q;
    assign o_dst        = dst_q;
    assign o_pc_plus4   = pc_plus4_q;
    assign o_opcode     = opcode_q;
    assign o_funct      = funct_q;
    assign o_reg_write  = reg_write_q;
    assign o_mem_read   = mem_read_q;
    assign o_mem_write  = mem_write_q;
    assign o_mem_to_reg = mem_to_reg_q;
    assign o_alu_src    = alu_src_q;
    assign o_branch     = branch_q;
    assign o_stall_cnt  = stall_cnt_q;

endmodule
